// File: rtl/check.sv
`default_nettype none
// ============================================================================
// Module      : check
// Description : Result checker. Pops one expected-result record from the check
//               FIFO and one captured DUT output word from the result FIFO,
//               compares them under a programmable bitmask, keeps saturating
//               pass/fail counters and writes a 5-word log record for each
//               failure through an Avalon-MM write master.
//               Optional feature macro: CHECK_LOG_PASS_EN (also log passes).
// Revision    : 1.0 - initial release
// ============================================================================
module check #(
    parameter int                    ADDR_WIDTH = 20,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    BE_WIDTH   = DATA_WIDTH / 8,
    parameter int                    STF_WIDTH  = 24,
    parameter int                    ORV_WIDTH  = 8,
    parameter int                    CHF_WIDTH  = STF_WIDTH + ORV_WIDTH + ADDR_WIDTH,
    parameter int                    SCC_WIDTH  = 5,
    parameter int                    SCD_WIDTH  = 24,
    parameter logic [ADDR_WIDTH-1:0] LOG_BASE   = 20'h80000,
    parameter int                    LOG_MAX    = 1024,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [CHF_WIDTH-1:0]  cfifo_data,
    output logic                  cfifo_rdreq,
    input  logic                  cfifo_rdempty,
    input  logic [STF_WIDTH-1:0]  rfifo_data,
    output logic                  rfifo_rdreq,
    input  logic                  rfifo_rdempty,
    input  logic [SCC_WIDTH-1:0]  sc_cmd,
    input  logic [SCD_WIDTH-1:0]  sc_data,
    input  logic                  sc_switching,
    output logic                  sc_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [BE_WIDTH-1:0]   mem_byteenable,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_writedata,
    input  logic                  mem_waitrequest,
    output logic [CNT_WIDTH-1:0]  pass_count,
    output logic [CNT_WIDTH-1:0]  fail_count,
    output logic                  busy
);

    localparam int                   c_LOGCNT_W = $clog2(LOG_MAX + 1);
    localparam logic [c_LOGCNT_W-1:0] c_LOG_MAX = c_LOGCNT_W'(LOG_MAX);
    localparam logic [SCC_WIDTH-1:0] c_CMD_BITMASK = SCC_WIDTH'(1);
    localparam logic [2:0]           c_LAST_WORD   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DISCARD = 3'd1,
        S_FETCH   = 3'd2,
        S_LATCH   = 3'd3,
        S_COMPARE = 3'd4,
        S_WRITE   = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [STF_WIDTH-1:0]    r_bitmask;
    logic [STF_WIDTH-1:0]    r_expected;
    logic [STF_WIDTH-1:0]    r_actual;
    logic [ADDR_WIDTH-1:0]   r_vaddr;
    logic [ORV_WIDTH-1:0]    r_orv;
    logic                    r_fail;
    logic [2:0]              r_widx;
    logic [ADDR_WIDTH-1:0]   r_log_addr;
    logic [c_LOGCNT_W-1:0]   r_log_cnt;
    logic [CNT_WIDTH-1:0]    r_pass_count;
    logic [CNT_WIDTH-1:0]    r_fail_count;
    logic                    w_fail;
    logic                    w_log_room;
    logic                    w_accept;
    logic [DATA_WIDTH-1:0]   w_word;

    assign w_fail     = |((r_expected ^ r_actual) & r_bitmask);
    assign w_log_room = (r_log_cnt < c_LOG_MAX);
    assign w_accept   = (r_state == S_WRITE) && !mem_waitrequest;

    assign sc_ready       = (r_state == S_IDLE) && cfifo_rdempty;
    assign busy           = (r_state != S_IDLE);
    assign cfifo_rdreq    = (r_state == S_FETCH);
    assign rfifo_rdreq    = (r_state == S_FETCH) || (r_state == S_DISCARD);
    assign mem_write      = (r_state == S_WRITE);
    assign mem_address    = r_log_addr;
    assign mem_byteenable = '1;
    assign mem_writedata  = mem_write ? w_word : '0;
    assign pass_count     = r_pass_count;
    assign fail_count     = r_fail_count;

    // Next-state selection; vectors in flight always run to completion.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (sc_switching && !rfifo_rdempty) begin
                    w_state_next = S_DISCARD;
                end else if (!sc_switching && !cfifo_rdempty && !rfifo_rdempty) begin
                    w_state_next = S_FETCH;
                end
            end
            S_DISCARD: w_state_next = S_IDLE;
            S_FETCH:   w_state_next = S_LATCH;
            S_LATCH:   w_state_next = S_COMPARE;
            S_COMPARE: begin
`ifdef CHECK_LOG_PASS_EN
                w_state_next = w_log_room ? S_WRITE : S_IDLE;
`else
                w_state_next = (w_fail && w_log_room) ? S_WRITE : S_IDLE;
`endif
            end
            S_WRITE: begin
                if (w_accept && (r_widx == c_LAST_WORD)) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Log record word selected by the current word index.
    always_comb begin
        w_word = '0;
        case (r_widx)
            3'd0:    w_word = DATA_WIDTH'({r_orv, r_fail, 3'b000, r_vaddr[19:16]});
            3'd1:    w_word = DATA_WIDTH'(r_vaddr[15:0]);
            3'd2:    w_word = DATA_WIDTH'(r_expected[15:0]);
            3'd3:    w_word = DATA_WIDTH'(r_actual[15:0]);
            3'd4:    w_word = DATA_WIDTH'({r_expected[23:16], r_actual[23:16]});
            default: w_word = '0;
        endcase
    end

    // State register, datapath capture, counters and log pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_bitmask    <= '1;
            r_expected   <= '0;
            r_actual     <= '0;
            r_vaddr      <= '0;
            r_orv        <= '0;
            r_fail       <= 1'b0;
            r_widx       <= 3'd0;
            r_log_addr   <= LOG_BASE;
            r_log_cnt    <= '0;
            r_pass_count <= '0;
            r_fail_count <= '0;
        end else begin
            r_state <= w_state_next;

            // Mask changes only while no expected record is queued.
            if (sc_ready && (sc_cmd == c_CMD_BITMASK)) begin
                r_bitmask <= sc_data[STF_WIDTH-1:0];
            end

            if (r_state == S_LATCH) begin
                {r_expected, r_vaddr, r_orv} <= cfifo_data;
                r_actual                     <= rfifo_data;
            end

            if (r_state == S_COMPARE) begin
                r_fail <= w_fail;
                r_widx <= 3'd0;
                if (w_fail) begin
                    if (r_fail_count != '1) begin
                        r_fail_count <= r_fail_count + 1'b1;
                    end
                end else begin
                    if (r_pass_count != '1) begin
                        r_pass_count <= r_pass_count + 1'b1;
                    end
                end
            end

            if (w_accept) begin
                r_log_addr <= r_log_addr + 1'b1;
                r_widx     <= r_widx + 3'd1;
                if (r_widx == c_LAST_WORD) begin
                    r_log_cnt <= r_log_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_check.sv
`default_nettype none
// ============================================================================
// Module      : tb_check
// Description : Directed, table-driven bench for the result checker, with
//               behavioural FIFOs and an Avalon-MM write slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_check;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [51:0] cfifo_data = '0;
    logic        cfifo_rdreq;
    logic        cfifo_rdempty;
    logic [23:0] rfifo_data = '0;
    logic        rfifo_rdreq;
    logic        rfifo_rdempty;
    logic [4:0]  sc_cmd = '0;
    logic [23:0] sc_data = '0;
    logic        sc_switching = 1'b0;
    logic        sc_ready;
    logic [19:0] mem_address;
    logic [1:0]  mem_byteenable;
    logic        mem_write;
    logic [15:0] mem_writedata;
    logic        mem_waitrequest = 1'b0;
    logic [15:0] pass_count;
    logic [15:0] fail_count;
    logic        busy;

    check dut (
        .clock          (clock),
        .reset          (reset),
        .cfifo_data     (cfifo_data),
        .cfifo_rdreq    (cfifo_rdreq),
        .cfifo_rdempty  (cfifo_rdempty),
        .rfifo_data     (rfifo_data),
        .rfifo_rdreq    (rfifo_rdreq),
        .rfifo_rdempty  (rfifo_rdempty),
        .sc_cmd         (sc_cmd),
        .sc_data        (sc_data),
        .sc_switching   (sc_switching),
        .sc_ready       (sc_ready),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_waitrequest(mem_waitrequest),
        .pass_count     (pass_count),
        .fail_count     (fail_count),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Behavioural FIFOs: data appears the cycle after rdreq.
    logic [51:0] cmem [16];
    logic [23:0] rmem [16];
    int cwp = 0, crp = 0, rwp = 0, rrp = 0;
    assign cfifo_rdempty = (cwp == crp);
    assign rfifo_rdempty = (rwp == rrp);

    always @(posedge clock) begin
        if (cfifo_rdreq) begin
            cfifo_data <= cmem[crp % 16];
            crp        <= crp + 1;
        end
        if (rfifo_rdreq) begin
            rfifo_data <= rmem[rrp % 16];
            rrp        <= rrp + 1;
        end
    end

    // Write slave: records every accepted word in order.
    logic [19:0] wa [64];
    logic [15:0] wd [64];
    int wn = 0;
    always @(posedge clock) begin
        if (mem_write && !mem_waitrequest) begin
            wa[wn % 64] <= mem_address;
            wd[wn % 64] <= mem_writedata;
            wn          <= wn + 1;
        end
    end

    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_c(input logic [51:0] d);
        cmem[cwp % 16] = d;
        cwp = cwp + 1;
    endtask

    task automatic push_r(input logic [23:0] d);
        rmem[rwp % 16] = d;
        rwp = rwp + 1;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while ((busy || !cfifo_rdempty || !rfifo_rdempty) && cyc < 60);
    endtask

    task automatic chk_record(input int base, input logic [19:0] addr0, input logic [79:0] words);
        logic [79:0] w;
        w = words;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rec_addr%0d", i), 32'(wa[(base + i) % 64]), 32'(addr0 + 20'(i)));
            chk($sformatf("rec_data%0d", i), 32'(wd[(base + i) % 64]), 32'(w[i*16 +: 16]));
        end
    endtask

    typedef struct packed {
        logic [23:0]      exp_v;
        logic [23:0]      act_v;
        logic [19:0]      vaddr;
        logic [7:0]       orv;
        logic             fail;
        logic [4:0][15:0] w;     // w[0] is the first word written
    } vec_t;

    vec_t vt [4];

    initial begin
        int          cyc;
        int          base;
        int          pe;
        int          fe;
        int          hit;
        int          rstart;
        int          cstart;
        logic [19:0] exp_addr;

        vt[0] = '{exp_v: 24'hA5A5A5, act_v: 24'hA5A5A5, vaddr: 20'h00012, orv: 8'h00,
                  fail: 1'b0, w: '0};
        vt[1] = '{exp_v: 24'h123456, act_v: 24'h12345F, vaddr: 20'h00034, orv: 8'h00,
                  fail: 1'b1, w: {16'h1212, 16'h345F, 16'h3456, 16'h0034, 16'h0080}};
        vt[2] = '{exp_v: 24'hFFFFFF, act_v: 24'h7FFFFF, vaddr: 20'hABCDE, orv: 8'h5A,
                  fail: 1'b1, w: {16'hFF7F, 16'hFFFF, 16'hFFFF, 16'hBCDE, 16'h5A8A}};
        vt[3] = '{exp_v: 24'h000000, act_v: 24'h000000, vaddr: 20'h00000, orv: 8'h00,
                  fail: 1'b0, w: '0};

        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_sc_ready", 32'(sc_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_writedata", 32'(mem_writedata), 32'd0);
        chk("rst_rdreq", 32'({cfifo_rdreq, rfifo_rdreq}), 32'd0);
        chk("rst_pass", 32'(pass_count), 32'd0);
        chk("rst_fail", 32'(fail_count), 32'd0);
        chk("byteenable", 32'(mem_byteenable), 32'd3);

        exp_addr = 20'h80000;
        pe = 0;
        fe = 0;

        // Table of single vectors under the reset bitmask.
        for (int k = 0; k < 4; k++) begin
            base = wn;
            push_c({vt[k].exp_v, vt[k].vaddr, vt[k].orv});
            push_r(vt[k].act_v);
            wait_idle(cyc);
            if (vt[k].fail) fe++; else pe++;
            chk($sformatf("v%0d_cycles", k), 32'(cyc), vt[k].fail ? 32'd9 : 32'd4);
            chk($sformatf("v%0d_pass", k), 32'(pass_count), 32'(pe));
            chk($sformatf("v%0d_fail", k), 32'(fail_count), 32'(fe));
            chk($sformatf("v%0d_nwrites", k), 32'(wn - base), vt[k].fail ? 32'd5 : 32'd0);
            if (vt[k].fail) begin
                chk_record(base, exp_addr, vt[k].w);
                exp_addr = exp_addr + 20'd5;
            end
        end

        // Bitmask load with the check FIFO empty hides the low-nibble mismatch.
        sc_cmd  = 5'd1;
        sc_data = 24'hFFFFF0;
        @(negedge clock);
        sc_cmd  = 5'd0;
        base = wn;
        push_c({24'h123456, 20'h00034, 8'h00});
        push_r(24'h12345F);
        wait_idle(cyc);
        pe++;
        chk("mask_cycles", 32'(cyc), 32'd4);
        chk("mask_pass", 32'(pass_count), 32'(pe));
        chk("mask_fail", 32'(fail_count), 32'(fe));
        chk("mask_nwrites", 32'(wn - base), 32'd0);

        // Command while a check record is queued must be ignored.
        push_c({24'h100000, 20'h00056, 8'h01});
        #1;
        chk("queued_sc_ready", 32'(sc_ready), 32'd0);
        sc_cmd  = 5'd1;
        sc_data = 24'h00000F;
        @(negedge clock);
        sc_cmd  = 5'd0;
        chk("queued_busy", 32'(busy), 32'd0);
        base = wn;
        push_r(24'h000000);
        wait_idle(cyc);
        fe++;
        chk("queued_cycles", 32'(cyc), 32'd9);
        chk("queued_fail", 32'(fail_count), 32'(fe));
        chk("queued_nwrites", 32'(wn - base), 32'd5);
        chk_record(base, exp_addr, {16'h1000, 16'h0000, 16'h0000, 16'h0056, 16'h0180});
        exp_addr = exp_addr + 20'd5;

        // Restore the full mask.
        sc_cmd  = 5'd1;
        sc_data = 24'hFFFFFF;
        @(negedge clock);
        sc_cmd  = 5'd0;

        // Slave stalls 4 cycles on word 2.
        base = wn;
        push_c({24'h00ABCD, 20'h00077, 8'h00});
        push_r(24'h00ABCE);
        hit = 0;
        for (int c = 0; c < 40 && hit == 0; c++) begin
            @(negedge clock);
            if (mem_write && (mem_address == exp_addr + 20'd2)) hit = 1;
        end
        chk("wait_w2_seen", 32'(hit), 32'd1);
        mem_waitrequest = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            chk("wait_addr", 32'(mem_address), 32'(exp_addr + 20'd2));
            chk("wait_data", 32'(mem_writedata), 32'h0000ABCD);
            chk("wait_write", 32'(mem_write), 32'd1);
        end
        chk("wait_accepted", 32'(wn - base), 32'd2);
        mem_waitrequest = 1'b0;
        wait_idle(cyc);
        fe++;
        chk("wait_nwrites", 32'(wn - base), 32'd5);
        chk("wait_fail", 32'(fail_count), 32'(fe));
        chk_record(base, exp_addr, {16'h0000, 16'hABCE, 16'hABCD, 16'h0077, 16'h0080});
        exp_addr = exp_addr + 20'd5;

        // Captures taken during a power switch are dropped without a compare.
        sc_switching = 1'b1;
        base   = wn;
        rstart = rrp;
        cstart = crp;
        push_r(24'h111111);
        push_r(24'h222222);
        push_r(24'h333333);
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (rfifo_rdempty && !busy) break;
        end
        chk("disc_pops", 32'(rrp - rstart), 32'd3);
        chk("disc_cfifo", 32'(crp - cstart), 32'd0);
        chk("disc_pass", 32'(pass_count), 32'(pe));
        chk("disc_fail", 32'(fail_count), 32'(fe));
        chk("disc_nwrites", 32'(wn - base), 32'd0);
        sc_switching = 1'b0;
        @(negedge clock);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_sc_ready", 32'(sc_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
